// File: rtl/uart_buf_ctrl_pkg.sv
// Shared types and default sizing for the UART buffer controller.
package uart_buf_ctrl_pkg;

    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_PAGE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_buf_ctrl_buf_fifo.sv
// Shift-register FIFO with count and parallel read; entry 0 is the oldest.
// In OVERWRITE mode a push into a full buffer discards the oldest entry.
module buf_fifo
    import uart_buf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter bit          OVERWRITE = 1'b0,
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_W-1:0]       din_i,
    output logic [CW-1:0]           cnt_o,
    output logic [DEPTH*DATA_W-1:0] ent_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d, wr_idx;
    logic              full, do_shift, do_write;

    // Vacated slots are refilled with zero so unoccupied entries always read 0.
    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        do_shift = (pop_i && (cnt_q != '0)) || (OVERWRITE && push_i && full && !pop_i);
        do_write = push_i && (!full || do_shift);
        wr_idx   = cnt_q - CW'(do_shift);
        mem_d    = mem_q;
        if (do_shift) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_write && (wr_idx == CW'(i))) begin
                mem_d[i] = din_i;
            end
        end
        cnt_d = wr_idx + CW'(do_write);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        ent_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_o[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_buf_ctrl.sv
// TX/RX byte buffers around an external UART, with a paged display view
// and a send FSM supporting single-shot and burst (auto) transmission.
module uart_buf_ctrl
    import uart_buf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned PAGE_W  = DEF_PAGE_W,
    localparam int unsigned CW     = $clog2(DEPTH) + 1,
    localparam int unsigned NPAGES = DEPTH / PAGE_W,
    localparam int unsigned PGW    = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [DATA_W-1:0]        din_i,
    input  logic                     send_i,
    input  logic                     auto_i,
    input  logic                     page_next_i,
    input  logic                     page_prev_i,
    input  logic                     sel_rx_i,
    output logic                     tx_start_o,
    output logic [DATA_W-1:0]        tx_data_o,
    input  logic                     tx_done_i,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     rx_done_i,
    output logic [PAGE_W*DATA_W-1:0] disp_o,
    output logic [PGW-1:0]           page_o,
    output logic                     disp_rx_o,
    output logic [CW-1:0]            tx_cnt_o,
    output logic [CW-1:0]            rx_cnt_o,
    output logic                     tx_busy_o,
    output logic                     tx_ovf_o
);

    tx_state_e                 state_q;
    logic                      tx_start_q, auto_q, ovf_q, disp_rx_q;
    logic [DATA_W-1:0]         tx_data_q;
    logic [PGW-1:0]            page_q, page_d;
    logic [PAGE_W*DATA_W-1:0]  disp_q, disp_d;
    logic [DEPTH*DATA_W-1:0]   tx_ent, rx_ent, sel_ent;
    logic [CW-1:0]             tx_cnt, rx_cnt;
    logic                      tx_has, tx_pop;

    // The pop happens on the edge entering START, so tx_data/tx_cnt are
    // already updated in the cycle tx_start_o is high.
    assign tx_has = (tx_cnt != '0);
    assign tx_pop = ((state_q == S_IDLE) && send_i && tx_has)
                 || ((state_q == S_WAIT) && tx_done_i && auto_q && tx_has);

    buf_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OVERWRITE(1'b0)) u_tx_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (load_i),
        .pop_i  (tx_pop),
        .din_i  (din_i),
        .cnt_o  (tx_cnt),
        .ent_o  (tx_ent)
    );

    buf_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OVERWRITE(1'b1)) u_rx_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (rx_done_i),
        .pop_i  (1'b0),
        .din_i  (rx_data_i),
        .cnt_o  (rx_cnt),
        .ent_o  (rx_ent)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            auto_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            tx_start_q <= tx_pop;
            if (tx_pop) begin
                tx_data_q <= tx_ent[DATA_W-1:0];
            end
            if (load_i && (tx_cnt == CW'(DEPTH)) && !tx_pop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (tx_pop) begin
                        state_q <= S_START;
                        auto_q  <= auto_i;
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (tx_done_i) begin
                        state_q <= tx_pop ? S_START : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        page_d = page_q;
        if (sel_rx_i) begin
            page_d = '0;
        end else if (page_next_i && !page_prev_i) begin
            page_d = (page_q == PGW'(NPAGES - 1)) ? '0 : page_q + PGW'(1);
        end else if (page_prev_i && !page_next_i) begin
            page_d = (page_q == '0) ? PGW'(NPAGES - 1) : page_q - PGW'(1);
        end
        sel_ent = disp_rx_q ? rx_ent : tx_ent;
        disp_d  = '0;
        for (int unsigned p = 0; p < NPAGES; p++) begin
            if (page_q == PGW'(p)) begin
                disp_d = sel_ent[p*PAGE_W*DATA_W +: PAGE_W*DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            page_q    <= '0;
            disp_rx_q <= 1'b0;
            disp_q    <= '0;
        end else begin
            page_q <= page_d;
            if (sel_rx_i) begin
                disp_rx_q <= ~disp_rx_q;
            end
            disp_q <= disp_d;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign tx_busy_o  = (state_q != S_IDLE);
    assign tx_ovf_o   = ovf_q;
    assign tx_cnt_o   = tx_cnt;
    assign rx_cnt_o   = rx_cnt;
    assign page_o     = page_q;
    assign disp_rx_o  = disp_rx_q;
    assign disp_o     = disp_q;

endmodule

// File: tb/tb_uart_buf_ctrl.sv
// Self-checking bench for uart_buf_ctrl: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_uart_buf_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PAGE_W = 2;
    localparam int unsigned NPAGES = DEPTH / PAGE_W;

    logic        clk = 1'b0;
    logic        rst, load_i, send_i, auto_i, page_next_i, page_prev_i, sel_rx_i;
    logic        tx_done_i, rx_done_i;
    logic [7:0]  din_i, rx_data_i;
    logic        tx_start_o, disp_rx_o, tx_busy_o, tx_ovf_o;
    logic [7:0]  tx_data_o;
    logic [15:0] disp_o;
    logic [0:0]  page_o;
    logic [2:0]  tx_cnt_o, rx_cnt_o;

    always #5 clk = ~clk;

    uart_buf_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PAGE_W(PAGE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_i),
        .din_i       (din_i),
        .send_i      (send_i),
        .auto_i      (auto_i),
        .page_next_i (page_next_i),
        .page_prev_i (page_prev_i),
        .sel_rx_i    (sel_rx_i),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_done_i   (tx_done_i),
        .rx_data_i   (rx_data_i),
        .rx_done_i   (rx_done_i),
        .disp_o      (disp_o),
        .page_o      (page_o),
        .disp_rx_o   (disp_rx_o),
        .tx_cnt_o    (tx_cnt_o),
        .rx_cnt_o    (rx_cnt_o),
        .tx_busy_o   (tx_busy_o),
        .tx_ovf_o    (tx_ovf_o)
    );

    typedef struct {
        logic       rst, load;
        logic [7:0] din;
        logic       send, auto_m, done;
        logic [7:0] rxd;
        logic       rx_done, pn, pp, sel;
    } in_t;

    typedef struct {
        in_t        in;
        logic       e_start;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic       e_busy, e_ovf;
    } row_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: buffers as queues, transmitter as busy/just-started flags.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_busy, m_start, m_auto, m_ovf, m_rx;
    int unsigned m_page;
    logic [7:0]  m_data;
    logic [15:0] m_disp;

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic in_t ld(input logic [7:0] d);
        in_t v;
        v = idle(); v.load = 1'b1; v.din = d;
        return v;
    endfunction

    function automatic in_t snd(input logic a);
        in_t v;
        v = idle(); v.send = 1'b1; v.auto_m = a;
        return v;
    endfunction

    function automatic in_t dn();
        in_t v;
        v = idle(); v.done = 1'b1;
        return v;
    endfunction

    function automatic row_t mkrow(input in_t v, input logic s, input logic [7:0] d,
                                   input logic [2:0] c, input logic b, input logic o);
        row_t r;
        r.in = v; r.e_start = s; r.e_data = d; r.e_cnt = c; r.e_busy = b; r.e_ovf = o;
        return r;
    endfunction

    function automatic logic [7:0] entry(input bit rx, input int unsigned k);
        if (rx) return (k < rx_q.size()) ? rx_q[k] : 8'h00;
        return (k < tx_q.size()) ? tx_q[k] : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        rst = v.rst; load_i = v.load; din_i = v.din; send_i = v.send;
        auto_i = v.auto_m; tx_done_i = v.done; rx_data_i = v.rxd;
        rx_done_i = v.rx_done; page_next_i = v.pn; page_prev_i = v.pp; sel_rx_i = v.sel;
    endtask

    task automatic model(input in_t v);
        int unsigned sz;
        bit accept, cont, done_w;
        logic [15:0] dnx;
        dnx = '0;
        for (int j = 0; j < PAGE_W; j++) dnx[j*8 +: 8] = entry(m_rx, m_page * PAGE_W + j);
        if (v.rst) begin
            tx_q.delete(); rx_q.delete();
            m_busy = 0; m_start = 0; m_auto = 0; m_ovf = 0; m_rx = 0;
            m_page = 0; m_data = '0; m_disp = '0;
            return;
        end
        m_disp = dnx;
        sz     = tx_q.size();
        accept = !m_busy && v.send && (sz > 0);
        done_w = m_busy && !m_start && v.done;
        cont   = done_w && m_auto && (sz > 0);
        if (accept) m_auto = v.auto_m;
        if (accept || cont) m_data = tx_q.pop_front();
        if (v.load) begin
            if (sz == DEPTH && !(accept || cont)) m_ovf = 1;
            else tx_q.push_back(v.din);
        end
        m_start = accept || cont;
        if (accept) m_busy = 1;
        else if (done_w && !cont) m_busy = 0;
        if (v.rx_done) begin
            rx_q.push_back(v.rxd);
            if (rx_q.size() > DEPTH) void'(rx_q.pop_front());
        end
        if (v.sel) begin
            m_rx = !m_rx; m_page = 0;
        end else if (v.pn && !v.pp) begin
            m_page = (m_page + 1) % NPAGES;
        end else if (v.pp && !v.pn) begin
            m_page = (m_page + NPAGES - 1) % NPAGES;
        end
    endtask

    task automatic check_all();
        chk("tx_start", tx_start_o, m_start);
        chk("tx_data", tx_data_o, m_data);
        chk("tx_cnt", tx_cnt_o, tx_q.size());
        chk("rx_cnt", rx_cnt_o, rx_q.size());
        chk("tx_busy", tx_busy_o, m_busy);
        chk("tx_ovf", tx_ovf_o, m_ovf);
        chk("page", page_o, m_page);
        chk("disp_rx", disp_rx_o, m_rx);
        chk("disp", disp_o, m_disp);
    endtask

    task automatic step(input in_t v);
        drive(v);
        @(posedge clk);
        model(v);
        #1;
        check_all();
    endtask

    task automatic reset_dut();
        in_t v;
        v = idle(); v.rst = 1'b1;
        step(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t tbl[13];
        in_t  v;
        int   n, cyc, w;

        drive(idle());
        reset_dut();

        // Single sends, overflow, and a load accepted alongside a pop.
        tbl[0]  = mkrow(ld(8'h11), 0, 8'h00, 3'd1, 0, 0);
        tbl[1]  = mkrow(ld(8'h22), 0, 8'h00, 3'd2, 0, 0);
        tbl[2]  = mkrow(ld(8'h33), 0, 8'h00, 3'd3, 0, 0);
        tbl[3]  = mkrow(snd(0),    1, 8'h11, 3'd2, 1, 0);
        tbl[4]  = mkrow(idle(),    0, 8'h11, 3'd2, 1, 0);
        tbl[5]  = mkrow(dn(),      0, 8'h11, 3'd2, 0, 0);
        tbl[6]  = mkrow(idle(),    0, 8'h11, 3'd2, 0, 0);
        tbl[7]  = mkrow(ld(8'h44), 0, 8'h11, 3'd3, 0, 0);
        tbl[8]  = mkrow(ld(8'h55), 0, 8'h11, 3'd4, 0, 0);
        tbl[9]  = mkrow(ld(8'h66), 0, 8'h11, 3'd4, 0, 1);
        v = snd(0); v.load = 1'b1; v.din = 8'h77;
        tbl[10] = mkrow(v,         1, 8'h22, 3'd4, 1, 1);
        tbl[11] = mkrow(idle(),    0, 8'h22, 3'd4, 1, 1);
        tbl[12] = mkrow(dn(),      0, 8'h22, 3'd4, 0, 1);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in);
            chk("tbl_start", tx_start_o, tbl[i].e_start);
            chk("tbl_data",  tx_data_o,  tbl[i].e_data);
            chk("tbl_cnt",   tx_cnt_o,   tbl[i].e_cnt);
            chk("tbl_busy",  tx_busy_o,  tbl[i].e_busy);
            chk("tbl_ovf",   tx_ovf_o,   tbl[i].e_ovf);
        end

        // Auto burst with variable uart_tx latency.
        reset_dut();
        for (int k = 1; k <= 4; k++) step(ld(8'(8'hA0 + k)));
        step(snd(1));
        v = idle(); v.auto_m = 1'b0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 200) begin
            if (tx_start_o) begin
                chk("burst_data", tx_data_o, 32'hA1 + n);
                n++;
                w = $urandom_range(0, 3);
                repeat (w) step(v);
                step(dn());
            end else begin
                step(v);
            end
            cyc++;
        end
        chk("burst_count", n, 4);
        step(idle());
        chk("burst_end_busy", tx_busy_o, 0);
        chk("burst_end_cnt", tx_cnt_o, 0);

        // RX overwrite-oldest and page wrap.
        reset_dut();
        for (int k = 1; k <= 6; k++) begin
            v = idle(); v.rx_done = 1'b1; v.rxd = 8'(k);
            step(v);
        end
        chk("rx_sat_cnt", rx_cnt_o, 4);
        v = idle(); v.sel = 1'b1; step(v);
        step(idle());
        chk("rx_page0", disp_o, 16'h0403);
        v = idle(); v.pn = 1'b1; step(v);
        step(idle());
        chk("rx_page1", disp_o, 16'h0605);
        v = idle(); v.pn = 1'b1; step(v);
        step(idle());
        chk("rx_page_wrap", disp_o, 16'h0403);
        v = idle(); v.pn = 1'b1; v.pp = 1'b1; step(v);
        chk("page_both_hold", page_o, 0);

        // Send on empty buffer; reset abandons a transfer in WAIT.
        reset_dut();
        step(snd(0));
        chk("empty_send_start", tx_start_o, 0);
        chk("empty_send_busy", tx_busy_o, 0);
        step(ld(8'h5A));
        step(snd(0));
        step(idle());
        chk("in_wait_busy", tx_busy_o, 1);
        reset_dut();
        chk("rst_busy", tx_busy_o, 0);
        chk("rst_txcnt", tx_cnt_o, 0);
        step(dn());
        chk("done_after_rst_start", tx_start_o, 0);
        chk("done_after_rst_busy", tx_busy_o, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            v = idle();
            v.rst     = ($urandom_range(0, 299) == 0);
            v.load    = ($urandom_range(0, 3) == 0);
            v.din     = 8'($urandom);
            v.send    = ($urandom_range(0, 5) == 0);
            v.auto_m  = 1'($urandom_range(0, 1));
            if (m_busy && !m_start) v.done = ($urandom_range(0, 2) == 0);
            else if (!m_busy)       v.done = ($urandom_range(0, 15) == 0);
            v.rx_done = ($urandom_range(0, 3) == 0);
            v.rxd     = 8'($urandom);
            v.pn      = ($urandom_range(0, 7) == 0);
            v.pp      = ($urandom_range(0, 7) == 0);
            v.sel     = ($urandom_range(0, 15) == 0);
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_buf_ctrl.md
UART_BUF_CTRL -- requirements
Module: uart_buf_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, TX/RX buffer entries (power of two, >=2); DATA_W, 8, bits per entry; PAGE_W, 2, entries shown per display page (divides DEPTH).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 load_i  in  1  one-cycle pulse; push din_i into TX buffer.
REQ-005 din_i  in  DATA_W  byte to load (switches).
REQ-006 send_i  in  1  one-cycle pulse; start transmission.
REQ-007 auto_i  in  1  0 = send one entry per send_i; 1 = drain whole TX buffer per send_i.
REQ-008 page_next_i / page_prev_i  in  1 each  one-cycle pulses; step display page.
REQ-009 sel_rx_i  in  1  one-cycle pulse; toggle displayed buffer (TX/RX).
REQ-010 tx_start_o  out  1  one-cycle start pulse to uart_tx.
REQ-011 tx_data_o  out  DATA_W  byte to uart_tx; held stable from tx_start_o until tx_done_i.
REQ-012 tx_done_i  in  1  one-cycle done pulse from uart_tx.
REQ-013 rx_data_i  in  DATA_W; rx_done_i  in  1  received byte and its one-cycle valid pulse from uart_rx.
REQ-014 disp_o  out  PAGE_W*DATA_W  current page contents, highest index in MSBs.
REQ-015 page_o  out  clog2(DEPTH/PAGE_W) (min 1)  current page index.
REQ-016 disp_rx_o  out  1  1 = RX buffer displayed.
REQ-017 tx_cnt_o / rx_cnt_o  out  clog2(DEPTH)+1 each  occupied entries.
REQ-018 tx_busy_o  out  1  FSM not IDLE; tx_ovf_o  out  1  sticky TX overflow.

Function
REQ-019 TX buffer SHALL be a FIFO; entry 0 = oldest; load_i appends, a transmission pops entry 0.
REQ-020 load_i with tx_cnt_o==DEPTH and no pop in the same cycle SHALL drop din_i and set tx_ovf_o (held until rst).
REQ-021 load_i coinciding with a pop SHALL be accepted even when full; tx_cnt_o unchanged.
REQ-022 TX FSM states SHALL be IDLE, START, WAIT.
REQ-023 IDLE: send_i with tx_cnt_o>0 -> START; send_i with tx_cnt_o==0 ignored; send_i outside IDLE ignored.
REQ-024 START: pop entry 0 into tx_data_o, assert tx_start_o for exactly one cycle -> WAIT; tx_start_o rises the cycle after send_i is sampled.
REQ-025 WAIT: on tx_done_i, if auto mode latched and tx_cnt_o>0 -> START, else -> IDLE.
REQ-026 auto_i SHALL be latched at the send_i acceptance; changes mid-burst have no effect.
REQ-027 Auto burst SHALL also transmit entries loaded during the burst, ending when the buffer is empty at a tx_done_i.
REQ-028 RX buffer SHALL hold the newest DEPTH bytes; on rx_done_i append rx_data_i; when full discard the oldest; rx_cnt_o saturates at DEPTH.
REQ-029 RX capture SHALL be independent of TX FSM state and auto_i.
REQ-030 Page p SHALL show entries p*PAGE_W .. p*PAGE_W+PAGE_W-1 of the selected buffer; unoccupied entries read 0.
REQ-031 page_next_i increments, page_prev_i decrements page_o, both wrapping; simultaneous pulses leave it unchanged.
REQ-032 sel_rx_i toggles disp_rx_o and resets page_o to 0.
REQ-033 disp_o SHALL be registered, one cycle after any buffer or page change.

Reset
REQ-034 rst SHALL force FSM to IDLE, empty both buffers, clear all entries to 0, and clear tx_start_o, tx_data_o, tx_busy_o, tx_ovf_o, page_o, disp_rx_o, disp_o, counts.
REQ-035 rst during START/WAIT SHALL abandon the burst; a later tx_done_i in IDLE is ignored.

Structure
REQ-036 A shared package SHALL hold the FSM state enum and the default DEPTH/DATA_W/PAGE_W constants.
REQ-037 One sub-module, buf_fifo (parametrised DEPTH/DATA_W, count output, parallel read of all entries), SHALL be instantiated for both TX and RX (RX in overwrite-oldest mode).

Verification
REQ-038 Load 0x11,0x22,0x33; auto_i=0; send_i -> tx_start_o next cycle with tx_data_o=0x11, tx_cnt_o=2; stays IDLE after tx_done_i.
REQ-039 Load 0xA1..0xA4; auto_i=1; one send_i -> four tx_start_o pulses in order 0xA1..0xA4, each only after preceding tx_done_i; ends IDLE, tx_cnt_o=0.
REQ-040 Load 5 bytes with DEPTH=4 -> 5th dropped, tx_ovf_o=1, tx_cnt_o=4; load coinciding with START pop accepted.
REQ-041 Six rx_done_i with 0x01..0x06 -> RX holds 0x03..0x06; sel_rx_i, page 0 -> disp_o=0x0403; page_next_i -> 0x0605; page_next_i again wraps -> 0x0403.
REQ-042 send_i on empty buffer -> no tx_start_o; rst asserted in WAIT -> tx_busy_o=0, buffers empty, next tx_done_i ignored.
